// File: rtl/led_display_arbiter.sv
// led_display_arbiter
//   Shares one 8-digit seven-segment display driver between NREQ requesters.
//   Ownership rotates round-robin. When others are waiting, an owner keeps the
//   display for at least DWELL_CYCLES cycles. Outputs are registered.
//
//   Optional build macro LED_ARB_TAG_EN: while an owner is shown, replace the
//   top nibble with {1'b1, owner index} so the leftmost digit reads 8+owner.
//   NREQ <= 8 is required when this macro is defined.
//
// Ports:
//   clk_100M      system clock
//   rst           synchronous active-high reset
//   req           per-requester level request
//   data_flat     requester words; requester i is bits [32*i+31:32*i]
//   freeze        1 = hold the dwell counter, so no dwell-based rotation
//   disp_data     word to the display driver
//   disp_enable   display driver enable
//   grant         one-hot owner; zero when idle
//   grant_idx     binary owner index; zero when idle
//   switch_pulse  high for one cycle when a new grant first becomes visible
module led_display_arbiter #(
    parameter int NREQ         = 4,
    parameter int DWELL_CYCLES = 100000000,
    parameter int CNT_W        = 27,
    parameter int IDX_W        = 2
) (
    input  logic                   clk_100M,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [32*NREQ-1:0]     data_flat,
    input  logic                   freeze,
    output logic [31:0]            disp_data,
    output logic                   disp_enable,
    output logic [NREQ-1:0]        grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   switch_pulse
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);

    logic [0:0]                state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          last_idx;

    logic [NREQ-1:0][31:0]     words;
    logic [NREQ-1:0]           others;
    logic                      take;
    logic                      drop;
    logic [IDX_W-1:0]          pick;
    logic [IDX_W-1:0]          sel_idx;
    logic [31:0]               sel_word;

    assign words = data_flat;

    // First set bit of v strictly after base, wrapping around; base itself is
    // examined last. Callers pass a vector with the current owner masked out
    // whenever the owner must not be re-selected.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                                 input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] p;
        logic             found;
        int               idx;
        p     = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(base) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && v[IDX_W'(idx)]) begin
                p     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return p;
    endfunction

    // grant is one-hot in SHOW, so this is everyone but the owner.
    assign others = req & ~grant;

    always_comb begin
        take = 1'b0;
        drop = 1'b0;
        pick = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    take = 1'b1;
                    pick = rr_pick(req, last_idx);
                end
            end
            default: begin
                // Owner drop wins over dwell expiry and ignores freeze.
                if (!req[grant_idx]) begin
                    if (|others) begin
                        take = 1'b1;
                        pick = rr_pick(others, grant_idx);
                    end else begin
                        drop = 1'b1;
                    end
                end else if (cnt == DWELL_MAX && !freeze && |others) begin
                    take = 1'b1;
                    pick = rr_pick(others, grant_idx);
                end
            end
        endcase
    end

    // The word shown next cycle comes from the owner that will be visible
    // then, so a new grant and its data appear together.
    assign sel_idx = take ? pick : grant_idx;

    always_comb begin
        sel_word = words[sel_idx];
`ifdef LED_ARB_TAG_EN
        sel_word[31:28] = {1'b1, 3'(sel_idx)};
`endif
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            last_idx     <= IDX_W'(NREQ - 1);
            disp_data    <= '0;
            disp_enable  <= 1'b0;
            grant        <= '0;
            grant_idx    <= '0;
            switch_pulse <= 1'b0;
        end else if (take) begin
            state        <= SHOW;
            cnt          <= '0;
            last_idx     <= pick;
            disp_data    <= sel_word;
            disp_enable  <= 1'b1;
            grant        <= NREQ'(1) << pick;
            grant_idx    <= pick;
            switch_pulse <= 1'b1;
        end else if (drop) begin
            // disp_data intentionally keeps its last value.
            state        <= IDLE;
            disp_enable  <= 1'b0;
            grant        <= '0;
            grant_idx    <= '0;
            switch_pulse <= 1'b0;
        end else begin
            switch_pulse <= 1'b0;
            if (state == SHOW) begin
                disp_data <= sel_word;
                if (!freeze && cnt < DWELL_MAX) cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
